log_operand_encoder: RTL and testbench



---
 rtl/log_operand_if.sv | 29 ++
 rtl/log_operand_encoder.sv | 121 ++++++++++++
 tb/tb_log_operand_encoder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/log_operand_if.sv
// Operand/result handshake bundle for the log multiplier front end.
// Producer and consumer sides share one interface instance.
interface log_operand_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  k_a;
  logic [3:0]  k_b;
  logic [14:0] frac_sum;
  logic        frac_carry;
  logic        zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  k_a, k_b, frac_sum,
    input  frac_carry, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output k_a, k_b, frac_sum,
    output frac_carry, zero
  );
endinterface

// File: rtl/log_operand_encoder.sv
// Two-stage front end of the logarithmic multiplier: leading-one
// detection, fraction alignment and fraction add behind valid/ready.
module log_operand_encoder #(
  parameter int WIDTH = 16
) (
  input logic       clk,
  input logic       rst_n,
  log_operand_if.slave bus
);

  localparam int KW = $clog2(WIDTH);
  localparam int FW = WIDTH - 1;

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] a_q, b_q;

  logic             out_v_q, out_v_d;
  logic [KW-1:0]    ka_q, kb_q;
  logic [FW-1:0]    fs_q;
  logic             fc_q, z_q;

  logic             s1_adv;
  logic             in_fire;
  logic             s2_load;

  logic [KW-1:0]    ka_c, kb_c;
  logic [FW-1:0]    xa_c, xb_c;
  logic [WIDTH-1:0] sum_c;
  logic [KW-1:0]    ka_d, kb_d;
  logic [FW-1:0]    fs_d;
  logic             fc_d, z_d;

  function automatic logic [KW-1:0] lead_one(
    input logic [WIDTH-1:0] v
  );
    lead_one = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) lead_one = KW'(i);
  endfunction

  // shifting the leading one to bit FW and truncating drops it
  function automatic logic [FW-1:0] norm(
    input logic [WIDTH-1:0] v,
    input logic [KW-1:0]    k
  );
    logic [WIDTH-1:0] sh;
    sh   = v << (KW'(FW) - k);
    norm = sh[FW-1:0];
  endfunction

  assign s1_adv      = !out_v_q | bus.out_ready;
  assign bus.in_ready = !s1_v_q | s1_adv;
  assign in_fire     = bus.in_valid & bus.in_ready;
  assign s2_load     = s1_adv & s1_v_q;

  assign s1_v_d  = in_fire | (s1_v_q & !s1_adv);
  assign out_v_d = s1_adv ? s1_v_q : out_v_q;

  always_comb begin
    ka_c  = lead_one(a_q);
    kb_c  = lead_one(b_q);
    xa_c  = norm(a_q, ka_c);
    xb_c  = norm(b_q, kb_c);
    sum_c = {1'b0, xa_c} + {1'b0, xb_c};
    z_d   = (a_q == '0) | (b_q == '0);
    ka_d  = ka_c;
    kb_d  = kb_c;
    fs_d  = sum_c[FW-1:0];
    fc_d  = sum_c[FW];
    if (z_d) begin
      ka_d = '0;
      kb_d = '0;
      fs_d = '0;
      fc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      out_v_q <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      out_v_q <= out_v_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (in_fire) begin
      a_q <= bus.a;
      b_q <= bus.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ka_q <= '0;
      kb_q <= '0;
      fs_q <= '0;
      fc_q <= 1'b0;
      z_q  <= 1'b0;
    end else if (s2_load) begin
      ka_q <= ka_d;
      kb_q <= kb_d;
      fs_q <= fs_d;
      fc_q <= fc_d;
      z_q  <= z_d;
    end
  end

  assign bus.out_valid  = out_v_q;
  assign bus.k_a        = ka_q;
  assign bus.k_b        = kb_q;
  assign bus.frac_sum   = fs_q;
  assign bus.frac_carry = fc_q;
  assign bus.zero       = z_q;

endmodule

// File: tb/tb_log_operand_encoder.sv
// Directed and streaming checks for log_operand_encoder.
// Vector table plus stall, reset-in-flight and latency sequences.
module tb_log_operand_encoder;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  log_operand_if bus ();

  log_operand_encoder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ka;
    logic [3:0]  kb;
    logic [14:0] fs;
    logic        fc;
    logic        z;
  } vec_t;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: k = top set bit; fraction = (v - 2^k) scaled up to 15 bits
  function automatic logic [24:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    int ka, kb, xa, xb, s;
    if (a == 0 || b == 0) return {4'd0, 4'd0, 15'd0, 1'b0, 1'b1};
    ka = -1;
    kb = -1;
    for (int i = 15; i >= 0; i--) begin
      if (ka < 0 && a[i]) ka = i;
      if (kb < 0 && b[i]) kb = i;
    end
    xa = (int'(a) - (1 << ka)) * (1 << (15 - ka));
    xb = (int'(b) - (1 << kb)) * (1 << (15 - kb));
    s  = xa + xb;
    return {4'(ka), 4'(kb), 15'(s % 32768), (s >= 32768), 1'b0};
  endfunction

  function automatic logic [24:0] cur_out();
    return {bus.k_a, bus.k_b, bus.frac_sum, bus.frac_carry, bus.zero};
  endfunction

  task automatic send_one(input vec_t v, input int idx);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.out_ready = 1'b1;
    #1;
    check($sformatf("v%0d_in_ready", idx), 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_lat1", idx), 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_valid", idx), 32'(bus.out_valid), 32'd1);
    check($sformatf("v%0d_k_a", idx), 32'(bus.k_a), 32'(v.ka));
    check($sformatf("v%0d_k_b", idx), 32'(bus.k_b), 32'(v.kb));
    check($sformatf("v%0d_fsum", idx), 32'(bus.frac_sum), 32'(v.fs));
    check($sformatf("v%0d_fcarry", idx), 32'(bus.frac_carry), 32'(v.fc));
    check($sformatf("v%0d_zero", idx), 32'(bus.zero), 32'(v.z));
    check($sformatf("v%0d_charsum", idx),
          32'(bus.k_a) + 32'(bus.k_b) + 32'(bus.frac_carry),
          32'(v.ka) + 32'(v.kb) + 32'(v.fc));
  endtask

  initial begin
    vec_t        vt[8];
    logic [15:0] sa[8];
    logic [15:0] sb[8];
    logic [24:0] exp_q[8];
    logic [24:0] cur, prev;
    logic        prev_stall, saw_block;
    int          sent, recv;
    vec_t        fresh;

    n_cmp = 0;
    n_err = 0;

    vt[0] = '{16'h0003, 16'h0005, 4'd1,  4'd2,  15'h6000, 1'b0, 1'b0};
    vt[1] = '{16'h0007, 16'h0007, 4'd2,  4'd2,  15'h4000, 1'b1, 1'b0};
    vt[2] = '{16'hFFFF, 16'h8000, 4'd15, 4'd15, 15'h7FFF, 1'b0, 1'b0};
    vt[3] = '{16'h0000, 16'h1234, 4'd0,  4'd0,  15'h0000, 1'b0, 1'b1};
    vt[4] = '{16'h1234, 16'h0000, 4'd0,  4'd0,  15'h0000, 1'b0, 1'b1};
    vt[5] = '{16'h0001, 16'h0001, 4'd0,  4'd0,  15'h0000, 1'b0, 1'b0};
    vt[6] = '{16'h8001, 16'h4000, 4'd15, 4'd14, 15'h0001, 1'b0, 1'b0};
    vt[7] = '{16'h00FF, 16'h0180, 4'd7,  4'd8,  15'h3F00, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_fields", 32'(cur_out()), 32'd0);

    for (int i = 0; i < 8; i++) send_one(vt[i], i);

    // explicit characteristic-adder result for 7 x 7
    check("char_add_7x7", 32'(4'd2) + 32'(4'd2) + 32'(1'b1), 32'd5);

    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = (i == 5) ? 16'h0000 : 16'($urandom);
      exp_q[i] = model(sa[i], sb[i]);
    end
    sent       = 0;
    recv       = 0;
    prev       = '0;
    prev_stall = 1'b0;
    saw_block  = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (sent < 8);
      if (sent < 8) begin
        bus.a = sa[sent];
        bus.b = sb[sent];
      end
      #1;
      cur = cur_out();
      if (prev_stall) check("stall_hold", 32'(cur), 32'(prev));
      if (!bus.in_ready) begin
        saw_block = 1'b1;
        check("held_pairs", 32'(sent - recv), 32'd2);
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream_res%0d", recv), 32'(cur), 32'(exp_q[recv]));
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = cur;
    end
    bus.in_valid = 1'b0;
    check("stream_recv", 32'(recv), 32'd8);
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_block", 32'(saw_block), 32'd1);
    @(negedge clk);
    check("stream_drained", 32'(bus.out_valid), 32'd0);

    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0003;
    bus.b         = 16'h0005;
    @(posedge clk);
    #1;
    bus.a = 16'h0007;
    bus.b = 16'h0007;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flight_valid", 32'(bus.out_valid), 32'd1);
    check("flight_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_fields", 32'(cur_out()), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", i), 32'(bus.out_valid), 32'd0);
    end
    fresh = vt[7];
    send_one(fresh, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
